// File: rtl/gen_pulse_window_if.sv
// Control/status bundle for gen_pulse_window: period tick, per-channel window config, pulse and status outputs.
// ch_pol_i is present only when GEN_PULSE_POLARITY_EN is defined.
interface gen_pulse_window_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 24
);
    logic                      tick_in;
    logic                      mode_i;
    logic                      arm_i;
    logic [NUM_CH-1:0]         ch_en_i;
    logic [NUM_CH*CNT_W-1:0]   ch_offset_i;
    logic [NUM_CH*CNT_W-1:0]   ch_width_i;
    logic                      clr_ovr_i;
`ifdef GEN_PULSE_POLARITY_EN
    logic [NUM_CH-1:0]         ch_pol_i;
`endif
    logic [NUM_CH-1:0]         pulse_o;
    logic                      period_start_o;
    logic [CNT_W-1:0]          phase_o;
    logic                      busy_o;
    logic                      overrun_o;

    modport master (
        output tick_in, mode_i, arm_i, ch_en_i, ch_offset_i, ch_width_i, clr_ovr_i,
`ifdef GEN_PULSE_POLARITY_EN
        output ch_pol_i,
`endif
        input  pulse_o, period_start_o, phase_o, busy_o, overrun_o
    );

    modport slave (
        input  tick_in, mode_i, arm_i, ch_en_i, ch_offset_i, ch_width_i, clr_ovr_i,
`ifdef GEN_PULSE_POLARITY_EN
        input  ch_pol_i,
`endif
        output pulse_o, period_start_o, phase_o, busy_o, overrun_o
    );
endinterface

// File: rtl/gen_pulse_window.sv
// Multi-channel periodic window generator: one (offset, width) window per channel per period.
// Optional per-channel output polarity under GEN_PULSE_POLARITY_EN.
module gen_pulse_window #(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned TICK_FREQ = 100,
    parameter int unsigned EXT_TICK  = 1,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CNT_W     = 24
) (
    input logic               clk,
    input logic               rst_n,
    gen_pulse_window_if.slave bus
);

    localparam int unsigned PERIOD = CLK_FREQ / TICK_FREQ;
    localparam int unsigned DIV_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned EW     = CNT_W + 1;
    localparam logic [CNT_W-1:0] PH_MAX = '1;

    logic [DIV_W-1:0]        div_q;
    logic                    tick_q;
    logic                    evt_c;
    logic                    div_wrap_c;

    logic [NUM_CH-1:0]       en_q;
    logic [NUM_CH*CNT_W-1:0] off_q;
    logic [NUM_CH*CNT_W-1:0] wid_q;
    logic                    gen_q;
    logic                    armed_q;
    logic                    gen_c;

    logic [CNT_W-1:0]        phase_q;
    logic [CNT_W-1:0]        phase_nxt_c;
    logic [NUM_CH-1:0]       pulse_q;
    logic                    period_start_q;
    logic                    busy_q;
    logic                    ovr_q;
    logic                    pulse_on_c;

    logic [NUM_CH-1:0]       active_c;
    logic [EW-1:0]           max_end_c;
    logic [EW-1:0]           win_start_c;
    logic [EW-1:0]           win_end_c;

`ifdef GEN_PULSE_POLARITY_EN
    logic [NUM_CH-1:0]       pol_q;
`endif

    // Period event source; the unused source is constant-pruned.
    assign div_wrap_c = (div_q == DIV_W'(PERIOD - 1));
    assign evt_c      = (EXT_TICK != 0) ? (bus.tick_in & ~tick_q) : div_wrap_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= bus.tick_in;
            div_q  <= div_wrap_c ? '0 : div_q + DIV_W'(1);
        end
    end

    // An event in one-shot mode generates if already armed or armed on that same cycle.
    assign gen_c = bus.mode_i ? (armed_q | bus.arm_i) : 1'b1;

    always_comb begin
        phase_nxt_c = phase_q;
        if (evt_c)
            phase_nxt_c = '0;
        else if (phase_q != PH_MAX)
            phase_nxt_c = phase_q + CNT_W'(1);
    end

    // Window compare is one bit wider so off+wid never wraps.
    always_comb begin
        active_c    = '0;
        max_end_c   = '0;
        win_start_c = '0;
        win_end_c   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            win_start_c = {1'b0, off_q[i*CNT_W +: CNT_W]};
            win_end_c   = win_start_c + {1'b0, wid_q[i*CNT_W +: CNT_W]};
            if (en_q[i]) begin
                active_c[i] = gen_q && ({1'b0, phase_q} >= win_start_c)
                                    && ({1'b0, phase_q} <  win_end_c);
                if (win_end_c > max_end_c)
                    max_end_c = win_end_c;
            end
        end
    end

`ifdef GEN_PULSE_POLARITY_EN
    assign pulse_on_c = |(pulse_q ^ pol_q);
`else
    assign pulse_on_c = |pulse_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q           <= '0;
            off_q          <= '0;
            wid_q          <= '0;
            gen_q          <= 1'b0;
            armed_q        <= 1'b0;
            phase_q        <= '0;
            pulse_q        <= '0;
            period_start_q <= 1'b0;
            busy_q         <= 1'b0;
            ovr_q          <= 1'b0;
`ifdef GEN_PULSE_POLARITY_EN
            pol_q          <= '0;
`endif
        end else begin
            period_start_q <= evt_c;
            phase_q        <= phase_nxt_c;
            if (evt_c) begin
                en_q    <= bus.ch_en_i;
                off_q   <= bus.ch_offset_i;
                wid_q   <= bus.ch_width_i;
                gen_q   <= gen_c;
                armed_q <= bus.mode_i ? 1'b0 : (armed_q | bus.arm_i);
                busy_q  <= gen_c;
`ifdef GEN_PULSE_POLARITY_EN
                pol_q   <= bus.ch_pol_i;
                pulse_q <= bus.ch_pol_i;
`else
                pulse_q <= '0;
`endif
            end else begin
                if (bus.arm_i)
                    armed_q <= 1'b1;
                busy_q <= gen_q && ({1'b0, phase_nxt_c} <= max_end_c);
`ifdef GEN_PULSE_POLARITY_EN
                pulse_q <= active_c ^ pol_q;
`else
                pulse_q <= active_c;
`endif
            end
            // A new overrun wins over a simultaneous clear.
            if (evt_c && pulse_on_c)
                ovr_q <= 1'b1;
            else if (bus.clr_ovr_i)
                ovr_q <= 1'b0;
        end
    end

    assign bus.pulse_o        = pulse_q;
    assign bus.period_start_o = period_start_q;
    assign bus.phase_o        = phase_q;
    assign bus.busy_o         = busy_q;
    assign bus.overrun_o      = ovr_q;

endmodule

// File: tb/tb_gen_pulse_window.sv
// Self-checking bench for gen_pulse_window: internal-divider instance (period 100) and external-tick instance (CNT_W=8).
module tb_gen_pulse_window;

    localparam int unsigned NCH = 2;
    localparam int unsigned WI  = 16;
    localparam int unsigned WE  = 8;
    localparam int          PER = 100;

    logic clk = 1'b0;
    logic rst_n_i;
    logic rst_n_e;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    gen_pulse_window_if #(.NUM_CH(NCH), .CNT_W(WI)) bi ();
    gen_pulse_window_if #(.NUM_CH(NCH), .CNT_W(WE)) be ();

    gen_pulse_window #(.CLK_FREQ(1000), .TICK_FREQ(10), .EXT_TICK(0), .NUM_CH(NCH), .CNT_W(WI))
        u_int (.clk(clk), .rst_n(rst_n_i), .bus(bi.slave));

    gen_pulse_window #(.CLK_FREQ(1000), .TICK_FREQ(10), .EXT_TICK(1), .NUM_CH(NCH), .CNT_W(WE))
        u_ext (.clk(clk), .rst_n(rst_n_e), .bus(be.slave));

    typedef struct {
        logic       mode;
        logic       arm;
        logic [1:0] en;
        int         off0, wid0, off1, wid1;
        logic       gen;
        int         f0, l0, c0, f1, l1, c1;
    } vec_t;

    vec_t vecs[8];
    vec_t sb[$];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic drive_int(input vec_t v);
        bi.mode_i      = v.mode;
        bi.arm_i       = v.arm;
        bi.ch_en_i     = v.en;
        bi.ch_offset_i = {WI'(v.off1), WI'(v.off0)};
        bi.ch_width_i  = {WI'(v.wid1), WI'(v.wid0)};
        sb.push_back(v);
    endtask

    task automatic check_int_reset(input string tag);
        chk({tag, " pulse"},  longint'(bi.pulse_o), 0);
        chk({tag, " pstart"}, longint'(bi.period_start_o), 0);
        chk({tag, " phase"},  longint'(bi.phase_o), 0);
        chk({tag, " busy"},   longint'(bi.busy_o), 0);
        chk({tag, " ovr"},    longint'(bi.overrun_o), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t cur;
        int   n, cnt, k, pp, off, me, f0, l0, c0, f1, l1, c1, exp_ph;

        //          mode arm  en     o0  w0  o1  w1 gen   f0  l0  c0   f1  l1  c1
        vecs[0] = '{1'b0, 1'b0, 2'b11,  5,  3,  0,  1, 1'b1,  6,  8,  3,   1,  1, 1};
        vecs[1] = '{1'b0, 1'b0, 2'b01, 10, 20,  0,  1, 1'b1, 11, 30, 20,  -1, -1, 0};
        vecs[2] = '{1'b0, 1'b0, 2'b11,  0,  0, 50,  5, 1'b1, -1, -1,  0,  51, 55, 5};
        vecs[3] = '{1'b0, 1'b0, 2'b11,  0, 98,  0,  1, 1'b1,  1, 98, 98,   1,  1, 1};
        vecs[4] = '{1'b1, 1'b0, 2'b11,  5,  3,  0,  1, 1'b0, -1, -1,  0,  -1, -1, 0};
        vecs[5] = '{1'b1, 1'b1, 2'b11,  5,  3,  0,  1, 1'b1,  6,  8,  3,   1,  1, 1};
        vecs[6] = '{1'b1, 1'b0, 2'b11,  5,  3,  0,  1, 1'b0, -1, -1,  0,  -1, -1, 0};
        vecs[7] = '{1'b0, 1'b0, 2'b01, 90, 20,  0,  1, 1'b1, 91, 99,  9,  -1, -1, 0};

        rst_n_i = 1'b0;
        rst_n_e = 1'b0;
        bi.tick_in = 1'b0;  bi.clr_ovr_i = 1'b0;
        be.tick_in = 1'b0;  be.clr_ovr_i = 1'b0;
        be.mode_i = 1'b0;   be.arm_i = 1'b0;  be.ch_en_i = 2'b01;
        be.ch_offset_i = {8'd0, 8'd5};
        be.ch_width_i  = {8'd0, 8'd3};
`ifdef GEN_PULSE_POLARITY_EN
        bi.ch_pol_i = '0;
        be.ch_pol_i = '0;
`endif
        drive_int(vecs[0]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_int_reset("reset");
        chk("ext reset pulse", longint'(be.pulse_o), 0);
        rst_n_i = 1'b1;
        rst_n_e = 1'b1;

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bi.period_start_o && n < 300);
        chk("first period delay", n, PER);

        // Table: config for period p+1 is driven mid-period p, so shadowing is exercised throughout.
        for (int p = 0; p < 8; p++) begin
            chk($sformatf("p%0d ovr idle", p), longint'(bi.overrun_o), 0);
            cur = sb.pop_front();
            if (p < 7) drive_int(vecs[p+1]);
            me = 0;
            if (cur.en[0]) me = cur.off0 + cur.wid0;
            if (cur.en[1] && (cur.off1 + cur.wid1) > me) me = cur.off1 + cur.wid1;
            f0 = -1; l0 = -1; c0 = 0; f1 = -1; l1 = -1; c1 = 0;
            for (int kk = 0; kk < PER; kk++) begin
                if (kk > 0) @(negedge clk);
                if (kk == 1) bi.arm_i = 1'b0;
                chk($sformatf("p%0d k%0d phase", p, kk), longint'(bi.phase_o), kk);
                chk($sformatf("p%0d k%0d pstart", p, kk), longint'(bi.period_start_o), (kk == 0) ? 1 : 0);
                chk($sformatf("p%0d k%0d busy", p, kk), longint'(bi.busy_o),
                    (cur.gen && kk <= me) ? 1 : 0);
                if (bi.pulse_o[0]) begin if (f0 < 0) f0 = kk; l0 = kk; c0++; end
                if (bi.pulse_o[1]) begin if (f1 < 0) f1 = kk; l1 = kk; c1++; end
            end
            chk($sformatf("p%0d ch0 first", p), f0, cur.f0);
            chk($sformatf("p%0d ch0 last", p),  l0, cur.l0);
            chk($sformatf("p%0d ch0 count", p), c0, cur.c0);
            chk($sformatf("p%0d ch1 first", p), f1, cur.f1);
            chk($sformatf("p%0d ch1 last", p),  l1, cur.l1);
            chk($sformatf("p%0d ch1 count", p), c1, cur.c1);
            @(negedge clk);
        end

        // Period 8: overrun from 90/20, then clear coincident with a second overrun.
        chk("ovr set", longint'(bi.overrun_o), 1);
        chk("ovr pulse dropped", longint'(bi.pulse_o), 0);
        chk("p8 pstart", longint'(bi.period_start_o), 1);
        for (int kk = 1; kk < PER; kk++) begin
            @(negedge clk);
            if (kk == 1) bi.ch_width_i = {WI'(1), WI'(0)};
            if (kk == 95) chk("shadow hold", longint'(bi.pulse_o[0]), 1);
        end
        bi.clr_ovr_i = 1'b1;
        @(negedge clk);
        bi.clr_ovr_i = 1'b0;
        chk("p9 pstart", longint'(bi.period_start_o), 1);
        chk("set beats clr", longint'(bi.overrun_o), 1);

        // Period 9: wid=0 gives nothing; clear alone; arm on the event cycle.
        cnt = 0;
        for (int kk = 1; kk < PER; kk++) begin
            @(negedge clk);
            if (bi.pulse_o[0]) cnt++;
            if (kk == 10) bi.clr_ovr_i = 1'b1;
            if (kk == 11) begin
                bi.clr_ovr_i = 1'b0;
                chk("clr alone", longint'(bi.overrun_o), 0);
                bi.mode_i      = 1'b1;
                bi.ch_offset_i = {WI'(0), WI'(0)};
                bi.ch_width_i  = {WI'(1), WI'(50)};
            end
        end
        chk("wid0 no pulse", cnt, 0);
        bi.arm_i = 1'b1;
        @(negedge clk);
        bi.arm_i = 1'b0;
        chk("p10 pstart", longint'(bi.period_start_o), 1);
        for (int kk = 1; kk <= 20; kk++) @(negedge clk);
        chk("arm coincident gen", longint'(bi.pulse_o[0]), 1);

        // One-cycle reset inside the window.
        rst_n_i = 1'b0;
        @(negedge clk);
        check_int_reset("mid reset");
        rst_n_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bi.period_start_o && n < 300);
        chk("restart delay", n, PER);

        // External tick: 50 high / 50 low; offset 5 -> 20 changed mid-period 1.
        for (int j = 0; j < 400; j++) begin
            if (j > 0) begin
                k   = (j - 1) % 100;
                pp  = (j - 1) / 100;
                off = (pp < 2) ? 5 : 20;
                chk($sformatf("ext j%0d pstart", j), longint'(be.period_start_o), (k == 0) ? 1 : 0);
                chk($sformatf("ext j%0d ch0", j), longint'(be.pulse_o[0]),
                    (k >= off + 1 && k <= off + 3) ? 1 : 0);
                chk($sformatf("ext j%0d ch1", j), longint'(be.pulse_o[1]), 0);
            end
            be.tick_in = ((j % 100) < 50);
            if (j == 130) be.ch_offset_i = {8'd0, 8'd20};
            @(negedge clk);
        end

        // Saturation: CNT_W=8, off=250 wid=10, tick period 300; ch1 enabled with wid=0.
        be.ch_en_i     = 2'b11;
        be.ch_offset_i = {8'd0, 8'd250};
        be.ch_width_i  = {8'd0, 8'd10};
        for (int s = 0; s <= 600; s++) begin
            if (s > 0) begin
                k      = (s - 1) % 300;
                exp_ph = (k > 255) ? 255 : k;
                chk($sformatf("sat s%0d pstart", s), longint'(be.period_start_o), (k == 0) ? 1 : 0);
                chk($sformatf("sat s%0d phase", s), longint'(be.phase_o), exp_ph);
                chk($sformatf("sat s%0d ch0", s), longint'(be.pulse_o[0]), (k >= 251) ? 1 : 0);
                chk($sformatf("sat s%0d ch1", s), longint'(be.pulse_o[1]), 0);
                chk($sformatf("sat s%0d ovr", s), longint'(be.overrun_o), (s >= 301) ? 1 : 0);
            end
            be.tick_in = ((s % 300) < 10);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
